// File: rtl/lcd_bus_monitor.sv
// Passive monitor for a 4-bit HD44780 bus: it syncs the bus, tracks the init handshake, rebuilds bytes and keeps a 2x16 shadow.
// Latency: a byte takes effect SYNC_STAGES clocks after the first low sample of E. No backpressure: it only listens and never drives the bus.
module lcd_bus_monitor #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_E,
    input  logic       iLCD_RS,
    input  logic       iLCD_RW,
    input  logic [3:0] iSF_DATA,
    input  logic [4:0] iReadAddr,
    output logic [7:0] oReadChar,
    output logic       oByteValid,
    output logic [7:0] oByte,
    output logic       oIsData,
    output logic [4:0] oCursor,
    output logic       oInitDone,
    output logic       oError
);

    typedef enum logic [1:0] {WAIT3, SYNC8, HI, LO} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0]      e_sr, rs_sr, rw_sr;
    logic [SYNC_STAGES-1:0][3:0] d_sr;
    logic       e_s, e_prev;
    logic       rs_lat, rw_lat;
    logic [3:0] d_lat;
    logic       nib_evt;

    logic [3:0] hi_nib;
    logic       hi_rs;
    logic       hi_load, byte_vld, set_init, set_err_fsm;
    logic [7:0] asm_byte;

    logic       cmd_clear, cmd_home, cmd_entry, cmd_addr_ok, cmd_addr_bad;
    logic [4:0] addr_idx;
    logic [6:0] addr_arg;

    logic [7:0] shadow [32];
    logic [4:0] cursor;
    logic       dir_inc;

    assign e_s      = e_sr[SYNC_STAGES-1];
    assign nib_evt  = e_prev & ~e_s & ~rw_lat;
    assign asm_byte = {hi_nib, d_lat};
    assign addr_arg = asm_byte[6:0];

    // Bus fields are captured while synced E is high, so the falling edge uses values seen before the drop.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            e_sr   <= '0;
            rs_sr  <= '0;
            rw_sr  <= '0;
            d_sr   <= '0;
            e_prev <= 1'b0;
            rs_lat <= 1'b0;
            rw_lat <= 1'b0;
            d_lat  <= 4'h0;
        end else begin
            e_sr   <= {e_sr[SYNC_STAGES-2:0], iLCD_E};
            rs_sr  <= {rs_sr[SYNC_STAGES-2:0], iLCD_RS};
            rw_sr  <= {rw_sr[SYNC_STAGES-2:0], iLCD_RW};
            d_sr   <= {d_sr[SYNC_STAGES-2:0], iSF_DATA};
            e_prev <= e_s;
            if (e_s) begin
                rs_lat <= rs_sr[SYNC_STAGES-1];
                rw_lat <= rw_sr[SYNC_STAGES-1];
                d_lat  <= d_sr[SYNC_STAGES-1];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= WAIT3;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        hi_load     = 1'b0;
        byte_vld    = 1'b0;
        set_init    = 1'b0;
        set_err_fsm = 1'b0;
        if (nib_evt) begin
            case (state)
                WAIT3: if (!rs_lat && d_lat == 4'h3) state_nxt = SYNC8;
                SYNC8: begin
                    if (!rs_lat) begin
                        if (d_lat == 4'h2) begin
                            state_nxt = HI;
                            set_init  = 1'b1;
                        end else if (d_lat != 4'h3) begin
                            set_err_fsm = 1'b1;
                        end
                    end
                end
                HI: begin
                    hi_load   = 1'b1;
                    state_nxt = LO;
                end
                LO: begin
                    byte_vld    = 1'b1;
                    set_err_fsm = (hi_rs != rs_lat);
                    state_nxt   = HI;
                end
                default: state_nxt = WAIT3;
            endcase
        end
    end

    always_comb begin
        cmd_clear    = (asm_byte == 8'h01);
        cmd_home     = (asm_byte[7:1] == 7'b0000001);
        cmd_entry    = (asm_byte[7:2] == 6'b000001);
        cmd_addr_ok  = 1'b0;
        cmd_addr_bad = 1'b0;
        addr_idx     = 5'd0;
        if (asm_byte[7]) begin
            // Line 1 DDRAM is 0x00-0x0F and line 2 is 0x40-0x4F; everything else is outside the visible window.
            if (addr_arg[6:4] == 3'b000) begin
                cmd_addr_ok = 1'b1;
                addr_idx    = {1'b0, addr_arg[3:0]};
            end else if (addr_arg[6:4] == 3'b100) begin
                cmd_addr_ok = 1'b1;
                addr_idx    = {1'b1, addr_arg[3:0]};
            end else begin
                cmd_addr_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) shadow[i] <= BLANK_CHAR;
            cursor     <= 5'd0;
            dir_inc    <= 1'b1;
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
            oByteValid <= 1'b0;
            oByte      <= 8'h00;
            oIsData    <= 1'b0;
            oInitDone  <= 1'b0;
            oError     <= 1'b0;
        end else begin
            oByteValid <= byte_vld;
            if (set_init) oInitDone <= 1'b1;
            if (set_err_fsm || (byte_vld && !rs_lat && cmd_addr_bad)) oError <= 1'b1;
            if (hi_load) begin
                hi_nib <= d_lat;
                hi_rs  <= rs_lat;
            end
            if (byte_vld) begin
                oByte   <= asm_byte;
                oIsData <= rs_lat;
                if (rs_lat) begin
                    shadow[cursor] <= asm_byte;
                    cursor         <= dir_inc ? cursor + 5'd1 : cursor - 5'd1;
                end else if (cmd_clear) begin
                    for (int i = 0; i < 32; i++) shadow[i] <= BLANK_CHAR;
                    cursor  <= 5'd0;
                    dir_inc <= 1'b1;
                end else if (cmd_home) begin
                    cursor <= 5'd0;
                end else if (cmd_entry) begin
                    dir_inc <= asm_byte[1];
                end else if (cmd_addr_ok) begin
                    cursor <= addr_idx;
                end
            end
        end
    end

    assign oReadChar = shadow[iReadAddr];
    assign oCursor   = cursor;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Randomised bus traffic against a byte-level display model, plus directed init, addressing, clear, error and reset cases.
module tb_lcd_bus_monitor;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iLCD_E, iLCD_RS, iLCD_RW;
    logic [3:0] iSF_DATA;
    logic [4:0] iReadAddr;
    logic [7:0] oReadChar;
    logic       oByteValid;
    logic [7:0] oByte;
    logic       oIsData;
    logic [4:0] oCursor;
    logic       oInitDone;
    logic       oError;

    lcd_bus_monitor #(.SYNC_STAGES(2), .BLANK_CHAR(8'h20)) dut (
        .Clock(Clock), .Reset(Reset),
        .iLCD_E(iLCD_E), .iLCD_RS(iLCD_RS), .iLCD_RW(iLCD_RW), .iSF_DATA(iSF_DATA),
        .iReadAddr(iReadAddr), .oReadChar(oReadChar),
        .oByteValid(oByteValid), .oByte(oByte), .oIsData(oIsData),
        .oCursor(oCursor), .oInitDone(oInitDone), .oError(oError)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Display model: what the panel should hold, in plain arithmetic.
    logic [7:0] m_shadow [32];
    int         m_cur, m_dir;
    bit         m_init, m_err, m_got3, m_four;
    logic [4:0] m_hi_q [$];
    logic [7:0] m_byte;
    bit         m_isdata, exp_vld;
    bit         chk_en = 1'b0;
    logic [4:0] rd_ptr = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
        m_cur = 0; m_dir = 1;
        m_init = 0; m_err = 0; m_got3 = 0; m_four = 0;
        m_hi_q.delete();
        m_byte = 8'h00; m_isdata = 0; exp_vld = 0;
    endtask

    task automatic mdl_exec(input logic rs, input logic [7:0] b);
        int a;
        if (rs) begin
            m_shadow[m_cur] = b;
            m_cur = (m_cur + m_dir + 32) % 32;
        end else if (b == 8'h01) begin
            for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
            m_cur = 0; m_dir = 1;
        end else if (b == 8'h02 || b == 8'h03) begin
            m_cur = 0;
        end else if (b >= 8'h04 && b <= 8'h07) begin
            m_dir = (b[1]) ? 1 : -1;
        end else if (b >= 8'h80) begin
            a = int'(b) - 128;
            if (a <= 15)                m_cur = a;
            else if (a >= 64 && a <= 79) m_cur = 16 + (a - 64);
            else                        m_err = 1;
        end
    endtask

    task automatic mdl_nibble(input logic rs, input logic [3:0] d);
        logic [4:0] hi;
        if (!m_four) begin
            if (rs) return;
            if (!m_got3) begin
                if (d == 4'h3) m_got3 = 1;
            end else if (d == 4'h2) begin
                m_four = 1; m_init = 1;
            end else if (d != 4'h3) begin
                m_err = 1;
            end
        end else if (m_hi_q.size() == 0) begin
            m_hi_q.push_back({rs, d});
        end else begin
            hi = m_hi_q.pop_front();
            if (hi[4] != rs) m_err = 1;
            m_byte = {hi[3:0], d};
            m_isdata = rs;
            exp_vld = 1;
            mdl_exec(rs, m_byte);
        end
    endtask

    // The model applies a nibble on the third clock that samples E low.
    task automatic send_nib(input logic rs, input logic rw, input logic [3:0] d);
        @(negedge Clock);
        iLCD_RS = rs; iLCD_RW = rw; iSF_DATA = d; iLCD_E = 1'b1;
        repeat (4) @(negedge Clock);
        iLCD_E = 1'b0;
        iLCD_RS = 1'($urandom_range(0, 1));
        iLCD_RW = 1'($urandom_range(0, 1));
        iSF_DATA = 4'($urandom_range(0, 15));
        repeat (3) @(posedge Clock);
        if (!rw) mdl_nibble(rs, d);
        @(posedge Clock);
        exp_vld = 0;
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        send_nib(rs, 1'b0, b[7:4]);
        send_nib(rs, 1'b0, b[3:0]);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        mdl_reset();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic do_init(input int junk);
        logic [3:0] v;
        for (int i = 0; i < junk; i++) begin
            v = 4'($urandom_range(4, 15));
            send_nib(1'($urandom_range(0, 1)), 1'b0, v);
        end
        send_nib(0, 0, 4'h3); send_nib(0, 0, 4'h3); send_nib(0, 0, 4'h3); send_nib(0, 0, 4'h2);
    endtask

    task automatic settle();
        @(negedge Clock);
        #2;
    endtask

    task automatic rand_op();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if (r < 50)      send_byte(1, 8'($urandom_range(0, 255)));
        else if (r < 56) send_byte(0, 8'h01);
        else if (r < 61) send_byte(0, 8'h02 | 8'($urandom_range(0, 1)));
        else if (r < 70) send_byte(0, 8'h04 | 8'($urandom_range(0, 3)));
        else if (r < 85) begin
            b = ($urandom_range(0, 1) == 1) ? (8'h80 | 8'($urandom_range(0, 15)))
                                            : (8'hC0 | 8'($urandom_range(0, 15)));
            send_byte(0, b);
        end
        else if (r < 92) send_nib(1'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 15)));
        else if (r < 97) send_byte(0, 8'($urandom_range(8, 127)));
        else             send_byte(0, 8'h80 | 8'($urandom_range(0, 127)));
    endtask

    // Per-cycle compare: read port sweeps all 32 entries continuously.
    initial begin
        forever begin
            @(negedge Clock);
            iReadAddr = rd_ptr;
            rd_ptr = rd_ptr + 5'd1;
            #1;
            if (chk_en) begin
                chk("cursor", 32'(oCursor), 32'(m_cur));
                chk("init_done", 32'(oInitDone), 32'(m_init));
                chk("error", 32'(oError), 32'(m_err));
                chk("byte_valid", 32'(oByteValid), 32'(exp_vld));
                chk("byte", 32'(oByte), 32'(m_byte));
                if (exp_vld) chk("is_data", 32'(oIsData), 32'(m_isdata));
                chk("read_char", 32'(oReadChar), 32'(m_shadow[iReadAddr]));
            end
        end
    end

    initial begin
        int blanks;
        Reset = 1'b1; iLCD_E = 1'b0; iLCD_RS = 1'b0; iLCD_RW = 1'b0; iSF_DATA = 4'h0;
        mdl_reset();
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        chk_en = 1'b1;
        settle();
        chk("rst_cursor", 32'(oCursor), 32'd0);
        chk("rst_init", 32'(oInitDone), 32'd0);
        chk("rst_byte", 32'(oByte), 32'd0);

        do_init(0);
        settle();
        chk("init_done_lit", 32'(oInitDone), 32'd1);
        chk("init_err_lit", 32'(oError), 32'd0);

        send_byte(0, 8'h80); send_byte(1, 8'h41); send_byte(1, 8'h62);
        settle();
        chk("ab_byte", 32'(oByte), 32'h62);
        chk("ab_cursor", 32'(oCursor), 32'd2);
        chk("ab_shadow0", 32'(m_shadow[0]), 32'h41);
        chk("ab_shadow1", 32'(m_shadow[1]), 32'h62);

        send_byte(0, 8'hCF); send_byte(1, 8'h58);
        settle();
        chk("l2_shadow31", 32'(m_shadow[31]), 32'h58);
        chk("l2_cursor", 32'(oCursor), 32'd0);
        send_byte(0, 8'h04); send_byte(1, 8'h59);
        settle();
        chk("dec_shadow0", 32'(m_shadow[0]), 32'h59);
        chk("dec_cursor", 32'(oCursor), 32'd31);

        send_byte(1, 8'h71); send_byte(1, 8'h72); send_byte(0, 8'h01);
        settle();
        blanks = 0;
        for (int i = 0; i < 32; i++) if (m_shadow[i] == 8'h20) blanks++;
        chk("clr_blanks", 32'(blanks), 32'd32);
        chk("clr_cursor", 32'(oCursor), 32'd0);
        send_byte(1, 8'h5A);
        settle();
        chk("clr_dir_cursor", 32'(oCursor), 32'd1);

        send_byte(0, 8'h90);
        settle();
        chk("bad_addr_err", 32'(oError), 32'd1);
        chk("bad_addr_cursor", 32'(oCursor), 32'd1);

        do_reset(); do_init(2);
        send_byte(1, 8'h31); send_byte(1, 8'h32); send_byte(1, 8'h33);
        send_nib(1, 0, 4'h8); send_nib(0, 0, 4'h1);
        settle();
        chk("rs_mix_err", 32'(oError), 32'd1);
        chk("rs_mix_cursor", 32'(oCursor), 32'd1);
        chk("rs_mix_byte", 32'(oByte), 32'h81);

        do_reset(); do_init(1);
        send_byte(1, 8'h61);
        send_nib(0, 1, 4'h8); send_nib(0, 0, 4'h8); send_nib(1, 1, 4'h5); send_nib(0, 0, 4'h5);
        settle();
        chk("rw_cursor", 32'(oCursor), 32'd5);
        chk("rw_err", 32'(oError), 32'd0);

        send_nib(1, 0, 4'h4);
        do_reset();
        settle();
        chk("mid_rst_init", 32'(oInitDone), 32'd0);
        do_init(0);
        send_byte(0, 8'h80); send_byte(1, 8'h41); send_byte(1, 8'h62);
        settle();
        chk("mid_rst_byte", 32'(oByte), 32'h62);
        chk("mid_rst_cursor", 32'(oCursor), 32'd2);

        for (int pass = 0; pass < 2; pass++) begin
            do_reset(); do_init(3);
            for (int n = 0; n < 150; n++) rand_op();
        end

        settle();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
